// File: rtl/mem_nr1w_sync_mask_write_bit_if.sv
// Bus bundle for the N-read/1-write bit-masked synchronous memory.
// The master side issues write and read requests; the slave side is the memory.
interface mem_nr1w_sync_mask_write_bit_if #(
    parameter int width_p      = 32,
    parameter int els_p        = 64,
    parameter int read_ports_p = 2
);
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

    // Write port
    logic                                    w_v_i;
    logic                                    w_ready_o;
    logic [addr_width_lp-1:0]                w_addr_i;
    logic [width_p-1:0]                      w_mask_i;
    logic [width_p-1:0]                      w_data_i;

    // Read ports, packed with port 0 in the least significant slice
    logic [read_ports_p-1:0]                 r_v_i;
    logic [read_ports_p-1:0]                 r_ready_o;
    logic [read_ports_p*addr_width_lp-1:0]   r_addr_i;
    logic [read_ports_p-1:0]                 r_data_v_o;
    logic [read_ports_p*width_p-1:0]         r_data_o;

    modport master (
        output w_v_i, w_addr_i, w_mask_i, w_data_i, r_v_i, r_addr_i,
        input  w_ready_o, r_ready_o, r_data_v_o, r_data_o
    );

    modport slave (
        input  w_v_i, w_addr_i, w_mask_i, w_data_i, r_v_i, r_addr_i,
        output w_ready_o, r_ready_o, r_data_v_o, r_data_o
    );
endinterface

// File: rtl/mem_nr1w_sync_mask_write_bit.sv
// N-read/1-write synchronous bit-masked memory built from one replicated
// 1RW bank per read port. Writes go to every bank; reads compete with the
// write through a small arbiter with a starvation counter so a pending write
// waits at most starve_limit_p cycles under continuous read traffic.
// Optional build macro MEM_NR1W_STALL_CNT_EN adds stall_cnt_o, a saturating
// count of cycles in which any request was held off.
module mem_nr1w_sync_mask_write_bit #(
    parameter int width_p        = 32,
    parameter int els_p          = 64,
    parameter int read_ports_p   = 2,
    parameter int starve_limit_p = 4
) (
    input  logic clk_i,
    input  logic nreset_i,
    mem_nr1w_sync_mask_write_bit_if.slave bus
`ifdef MEM_NR1W_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);
    localparam int addr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int starve_width_lp = (starve_limit_p > 0) ? $clog2(starve_limit_p + 1) : 1;
    localparam logic [starve_width_lp-1:0] starve_limit_lp = starve_width_lp'(starve_limit_p);

    logic                                  any_r;
    logic                                  wgrant;
    logic [read_ports_p-1:0]               r_fire;

    logic [starve_width_lp-1:0]            starve_cnt_q;
    logic [starve_width_lp-1:0]            starve_cnt_d;

    logic [read_ports_p-1:0]               r_data_v_q;
    logic [read_ports_p-1:0]               r_data_v_d;
    logic [read_ports_p-1:0][width_p-1:0]  hold_q;
    logic [read_ports_p-1:0][width_p-1:0]  hold_d;
    logic [read_ports_p-1:0][width_p-1:0]  bank_rdata;

    // Arbitration: reads win unless the write has lost starve_limit_p times.
    always_comb begin
        any_r  = |bus.r_v_i;
        wgrant = bus.w_v_i & (~any_r | (starve_cnt_q == starve_limit_lp));
        r_fire = bus.r_v_i & {read_ports_p{~wgrant}};
    end

    assign bus.w_ready_o = wgrant;
    assign bus.r_ready_o = {read_ports_p{~wgrant}};

    // Starvation counter: counts consecutive refusals of a pending write.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (wgrant || !bus.w_v_i) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != starve_limit_lp) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // One bank per read port; every bank takes every write so they stay identical.
    generate
        for (genvar gi = 0; gi < read_ports_p; gi++) begin : g_bank
            logic [width_p-1:0]       mem_r [els_p];
            logic [width_p-1:0]       bank_rdata_q;
            logic [addr_width_lp-1:0] bank_addr;

            assign bank_addr = wgrant ? bus.w_addr_i
                                      : bus.r_addr_i[gi*addr_width_lp +: addr_width_lp];

            // Bank port: bit-masked write or registered read, never both.
            always_ff @(posedge clk_i) begin
                if (wgrant) begin
                    for (int b = 0; b < width_p; b++) begin
                        if (bus.w_mask_i[b]) begin
                            mem_r[bank_addr][b] <= bus.w_data_i[b];
                        end
                    end
                end else if (r_fire[gi]) begin
                    bank_rdata_q <= mem_r[bank_addr];
                end
            end

            assign bank_rdata[gi] = bank_rdata_q;
        end
    endgenerate

    // Output selection: fresh bank data on the valid cycle, held data otherwise.
    always_comb begin
        r_data_v_d = r_fire;
        hold_d     = hold_q;
        for (int i = 0; i < read_ports_p; i++) begin
            if (r_data_v_q[i]) begin
                hold_d[i] = bank_rdata[i];
            end
        end
    end

    assign bus.r_data_v_o = r_data_v_q;
    assign bus.r_data_o   = hold_d;

    // Read valid pulse and per-port hold registers.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_data_v_q <= '0;
            hold_q     <= '0;
        end else begin
            r_data_v_q <= r_data_v_d;
            hold_q     <= hold_d;
        end
    end

`ifdef MEM_NR1W_STALL_CNT_EN
    logic        stall_cyc;
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    // A cycle counts once if any read or the write was refused.
    always_comb begin
        stall_cyc   = (|(bus.r_v_i & ~bus.r_ready_o)) | (bus.w_v_i & ~wgrant);
        stall_cnt_d = stall_cnt_q;
        if (stall_cyc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_mem_nr1w_sync_mask_write_bit.sv
// Directed bench for mem_nr1w_sync_mask_write_bit with a behavioural model
// (plain array plus per-port expected result/hold values) checked every cycle.
module tb_mem_nr1w_sync_mask_write_bit;
    localparam int W   = 32;
    localparam int E   = 64;
    localparam int P   = 2;
    localparam int AW  = 6;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic nreset_n = 1'b1;
    always #5 clk = ~clk;

    mem_nr1w_sync_mask_write_bit_if #(.width_p(W), .els_p(E), .read_ports_p(P)) bus_if ();

`ifdef MEM_NR1W_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    mem_nr1w_sync_mask_write_bit #(
        .width_p(W), .els_p(E), .read_ports_p(P), .starve_limit_p(LIM)
    ) dut (
        .clk_i(clk),
        .nreset_i(nreset_n),
        .bus(bus_if)
`ifdef MEM_NR1W_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;

    // Model state
    logic [W-1:0] mem_m [E];
    int           wait_m;
    bit           pend_v_m [P];
    logic [W-1:0] pend_d_m [P];
    logic [W-1:0] hold_m [P];
    longint       stall_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_grant();
        return bus_if.w_v_i && (!(|bus_if.r_v_i) || wait_m >= LIM);
    endfunction

    task automatic model_clear();
        wait_m  = 0;
        stall_m = 0;
        for (int i = 0; i < P; i++) begin
            pend_v_m[i] = 1'b0;
            pend_d_m[i] = '0;
            hold_m[i]   = '0;
        end
    endtask

    // Compare process: DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        bit g;
        if (armed) begin
            if (!nreset_n) model_clear();
            g = exp_grant();
            chk("w_ready", 64'(bus_if.w_ready_o), 64'(g));
            chk("r_ready", 64'(bus_if.r_ready_o), 64'({P{~g}}));
            for (int i = 0; i < P; i++) begin
                chk($sformatf("r_data_v[%0d]", i), 64'(bus_if.r_data_v_o[i]), 64'(pend_v_m[i]));
                chk($sformatf("r_data[%0d]", i), 64'(bus_if.r_data_o[i*W +: W]),
                    64'(pend_v_m[i] ? pend_d_m[i] : hold_m[i]));
            end
`ifdef MEM_NR1W_STALL_CNT_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
`endif
        end
    end

    // Model update on the active edge, from the inputs presented that cycle.
    always @(posedge clk) begin
        bit g;
        int a;
        if (armed) begin
            if (!nreset_n) begin
                model_clear();
            end else begin
                g = exp_grant();
                if (((|bus_if.r_v_i) && g) || (bus_if.w_v_i && !g)) begin
                    if (stall_m < 64'hFFFF_FFFF) stall_m++;
                end
                for (int i = 0; i < P; i++) begin
                    if (pend_v_m[i]) hold_m[i] = pend_d_m[i];
                    pend_v_m[i] = bus_if.r_v_i[i] && !g;
                    if (pend_v_m[i]) begin
                        a = int'(bus_if.r_addr_i[i*AW +: AW]);
                        pend_d_m[i] = mem_m[a];
                    end
                end
                if (g) begin
                    a = int'(bus_if.w_addr_i);
                    mem_m[a] = (mem_m[a] & ~bus_if.w_mask_i) | (bus_if.w_data_i & bus_if.w_mask_i);
                    wait_m = 0;
                end else if (bus_if.w_v_i) begin
                    wait_m++;
                end else begin
                    wait_m = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_write(input logic [AW-1:0] addr, input logic [W-1:0] data, input logic [W-1:0] mask);
        bus_if.w_v_i    = 1'b1;
        bus_if.w_addr_i = addr;
        bus_if.w_data_i = data;
        bus_if.w_mask_i = mask;
    endtask

    task automatic set_read(input logic [P-1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus_if.r_v_i    = v;
        bus_if.r_addr_i = {a1, a0};
    endtask

    logic [W-1:0] t4_data [3];
    logic [W-1:0] t4_mask [3];
    int k;

    initial begin
        for (int i = 0; i < E; i++) mem_m[i] = '0;
        model_clear();
        bus_if.w_v_i = 1'b0; bus_if.w_addr_i = '0; bus_if.w_data_i = '0; bus_if.w_mask_i = '0;
        bus_if.r_v_i = '0;   bus_if.r_addr_i = '0;
        t4_data[0] = 32'h1111_1111; t4_mask[0] = 32'hFFFF_FFFF;
        t4_data[1] = 32'h2222_2222; t4_mask[1] = 32'hFFFF_0000;
        t4_data[2] = 32'h3333_3333; t4_mask[2] = 32'h0000_00FF;

        #1 nreset_n = 1'b0;
        armed = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rst_data_v", 64'(bus_if.r_data_v_o), 64'h0);
        chk("rst_data", 64'(bus_if.r_data_o), 64'h0);
        tick();
        nreset_n = 1'b1;

        // Full write, then both ports read it back.
        set_write(6'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("t1_w_ready", 64'(bus_if.w_ready_o), 64'h1);
        tick();
        bus_if.w_v_i = 1'b0;
        set_read(2'b11, 6'd5, 6'd5);
        @(negedge clk);
        chk("t1_r_ready", 64'(bus_if.r_ready_o), 64'h3);
        tick();
        bus_if.r_v_i = '0;
        @(negedge clk);
        chk("t1_data_v", 64'(bus_if.r_data_v_o), 64'h3);
        chk("t1_data", 64'(bus_if.r_data_o), 64'hDEADBEEF_DEADBEEF);
        tick();
        @(negedge clk);
        chk("t1_pulse_end", 64'(bus_if.r_data_v_o), 64'h0);
        chk("t1_hold", 64'(bus_if.r_data_o), 64'hDEADBEEF_DEADBEEF);
        tick();

        // Masked write clears only the low half.
        set_write(6'd5, 32'h0, 32'h0000_FFFF);
        tick();
        bus_if.w_v_i = 1'b0;
        set_read(2'b11, 6'd5, 6'd5);
        tick();
        bus_if.r_v_i = '0;
        @(negedge clk);
        chk("t2_data", 64'(bus_if.r_data_o), 64'hDEAD0000_DEAD0000);
        tick();

        // Write starved by continuous reads until forced on the fifth cycle.
        set_write(6'd7, 32'h1234_5678, 32'hFFFF_FFFF);
        set_read(2'b11, 6'd5, 6'd5);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("t3_w_ready_c%0d", c), 64'(bus_if.w_ready_o), (c == 5) ? 64'h1 : 64'h0);
            chk($sformatf("t3_r_ready_c%0d", c), 64'(bus_if.r_ready_o), (c == 5) ? 64'h0 : 64'h3);
            tick();
        end
        bus_if.w_v_i = 1'b0;
        @(negedge clk);
        chk("t3_r_ready_resume", 64'(bus_if.r_ready_o), 64'h3);
`ifdef MEM_NR1W_STALL_CNT_EN
        chk("t3_stall_cnt", 64'(stall_cnt), 64'd5);
`endif
        tick();
        bus_if.r_v_i = '0;
        tick();
        set_read(2'b01, 6'd7, 6'd0);
        tick();
        bus_if.r_v_i = '0;
        @(negedge clk);
        chk("t3_rd7", 64'(bus_if.r_data_o[W-1:0]), 64'h1234_5678);
        tick();

        // Port 1 holds its last read across later writes.
        set_write(6'd3, 32'hA5A5_0F0F, 32'hFFFF_FFFF);
        tick();
        bus_if.w_v_i = 1'b0;
        set_read(2'b10, 6'd0, 6'd3);
        tick();
        bus_if.r_v_i = '0;
        @(negedge clk);
        chk("t4_data_v", 64'(bus_if.r_data_v_o), 64'h2);
        chk("t4_data", 64'(bus_if.r_data_o[2*W-1:W]), 64'hA5A5_0F0F);
        for (int j = 0; j < 3; j++) begin
            tick();
            set_write(6'd3, t4_data[j], t4_mask[j]);
            @(negedge clk);
            chk($sformatf("t4_v_w%0d", j), 64'(bus_if.r_data_v_o), 64'h0);
            chk($sformatf("t4_hold_w%0d", j), 64'(bus_if.r_data_o[2*W-1:W]), 64'hA5A5_0F0F);
        end
        tick();
        bus_if.w_v_i = 1'b0;
        set_read(2'b01, 6'd3, 6'd0);
        tick();
        bus_if.r_v_i = '0;
        @(negedge clk);
        chk("t4_merged", 64'(bus_if.r_data_o[W-1:0]), 64'h2222_1133);
        chk("t4_p1_hold", 64'(bus_if.r_data_o[2*W-1:W]), 64'hA5A5_0F0F);
        tick();

        // Reset mid-cycle after reads fire and a write has been starving.
        set_write(6'd9, 32'hCAFE_F00D, 32'hFFFF_FFFF);
        set_read(2'b11, 6'd5, 6'd5);
        tick(); tick();
        #1 nreset_n = 1'b0;
        @(negedge clk);
        chk("t5_v_rst", 64'(bus_if.r_data_v_o), 64'h0);
        chk("t5_d_rst", 64'(bus_if.r_data_o), 64'h0);
        tick(); tick();
        nreset_n = 1'b1;
        k = 1;
        @(negedge clk);
        chk("t5_no_pulse", 64'(bus_if.r_data_v_o), 64'h0);
        while (!bus_if.w_ready_o && k < 20) begin
            tick();
            @(negedge clk);
            k++;
        end
        chk("t5_grant_cycle", 64'(k), 64'd5);
        tick();
        bus_if.w_v_i = 1'b0;
        bus_if.r_v_i = '0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
